// File: rtl/poly_operand_sel.sv
// ============================================================================
//  Module   : poly_operand_sel
//  Brief    : Selects one of NUM_IN polynomials on start, snapshots it and
//             streams it out as LANES-coefficient beats under valid/ready.
//             Optional macro POLY_SEL_REDUCE_EN adds a per-lane conditional
//             subtraction of KYBER_Q on the output path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef KYBER_N
`define KYBER_N 256
`endif
`ifndef KYBER_Q
`define KYBER_Q 3329
`endif

module poly_operand_sel #(
    parameter int NUM_IN  = 5,
    parameter int N       = `KYBER_N,
    parameter int COEFF_W = 16,
    parameter int LANES   = 16,
    parameter int SEL_W   = $clog2(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN*N*COEFF_W-1:0] in_flat,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        start,
    output logic                        start_ready,
    output logic [LANES*COEFF_W-1:0]    out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        done,
    output logic                        err
);

    localparam int POLY_W = N * COEFF_W;
    localparam int BEAT_W = LANES * COEFF_W;
    localparam int BEATS  = N / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_STREAM = 1'b1;

    logic [0:0]        r_state;
    logic [POLY_W-1:0] r_snap;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic              r_err;

    logic [POLY_W-1:0] w_cand [NUM_IN];
    logic [BEAT_W-1:0] w_beat [BEATS];
    logic [BEAT_W-1:0] w_beat_out;
    logic              w_sel_ok;
    logic              w_last;
    logic              w_streaming;

    genvar gk;
    generate
        for (gk = 0; gk < NUM_IN; gk++) begin : g_cand
            assign w_cand[gk] = in_flat[gk*POLY_W +: POLY_W];
        end
        for (gk = 0; gk < BEATS; gk++) begin : g_beat
            assign w_beat[gk] = r_snap[gk*BEAT_W +: BEAT_W];
        end
    endgenerate

    // Extra MSB so the compare still works when NUM_IN is a power of two.
    assign w_sel_ok    = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
    assign w_streaming = (r_state == c_STREAM);
    assign w_last      = (r_cnt == CNT_W'(BEATS - 1));

    generate
        for (gk = 0; gk < LANES; gk++) begin : g_lane
            logic [COEFF_W-1:0] w_lane;
            assign w_lane = w_beat[r_cnt][gk*COEFF_W +: COEFF_W];
`ifdef POLY_SEL_REDUCE_EN
            localparam logic [COEFF_W-1:0] c_KYBER_Q = COEFF_W'(`KYBER_Q);
            assign w_beat_out[gk*COEFF_W +: COEFF_W] =
                (w_lane >= c_KYBER_Q) ? (w_lane - c_KYBER_Q) : w_lane;
`else
            assign w_beat_out[gk*COEFF_W +: COEFF_W] = w_lane;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_snap  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_sel_ok) begin
                            r_snap  <= w_cand[sel];
                            r_cnt   <= '0;
                            r_state <= c_STREAM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_STREAM: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign start_ready = ~w_streaming;
    assign out_valid   = w_streaming;
    assign out_last    = w_streaming & w_last;
    assign out_data    = w_streaming ? w_beat_out : '0;
    assign done        = r_done;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_poly_operand_sel.sv
// ============================================================================
//  Module   : tb_poly_operand_sel
//  Brief    : Directed self-checking bench for poly_operand_sel.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_poly_operand_sel;

    localparam int NUM_IN  = 5;
    localparam int N       = 256;
    localparam int COEFF_W = 16;
    localparam int LANES   = 16;
    localparam int SEL_W   = 3;
    localparam int BEATS   = N / LANES;
    localparam int BEAT_W  = LANES * COEFF_W;
    localparam int FLAT_W  = NUM_IN * N * COEFF_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [FLAT_W-1:0] in_flat;
    logic [SEL_W-1:0]  sel;
    logic              start;
    logic              start_ready;
    logic [BEAT_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    poly_operand_sel #(
        .NUM_IN (NUM_IN),
        .N      (N),
        .COEFF_W(COEFF_W),
        .LANES  (LANES),
        .SEL_W  (SEL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flat    (in_flat),
        .sel        (sel),
        .start      (start),
        .start_ready(start_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BEAT_W-1:0] obs,
                       input logic [BEAT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [COEFF_W-1:0] red(input logic [COEFF_W-1:0] v);
`ifdef POLY_SEL_REDUCE_EN
        return (v >= 16'd3329) ? v - 16'd3329 : v;
`else
        return v;
`endif
    endfunction

    // Expected beat b of input k under the k*1000+i fill pattern.
    function automatic logic [BEAT_W-1:0] exp_beat(input int k, input int b);
        logic [BEAT_W-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++)
            r[j*COEFF_W +: COEFF_W] = red(COEFF_W'(k*1000 + b*LANES + j));
        return r;
    endfunction

    task automatic load_pattern();
        for (int k = 0; k < NUM_IN; k++)
            for (int i = 0; i < N; i++)
                in_flat[(k*N+i)*COEFF_W +: COEFF_W] = COEFF_W'(k*1000 + i);
    endtask

    task automatic scramble();
        for (int w = 0; w < FLAT_W/32; w++)
            in_flat[w*32 +: 32] = $urandom;
    endtask

    task automatic run_full(input int k, input string tag);
        for (int b = 0; b < BEATS; b++) begin
            chk({tag, "_valid"}, BEAT_W'(out_valid), 1);
            chk({tag, "_data"}, out_data, exp_beat(k, b));
            chk({tag, "_last"}, BEAT_W'(out_last), BEAT_W'(b == BEATS-1));
            chk({tag, "_nodone"}, BEAT_W'(done), 0);
            tick();
        end
        chk({tag, "_done"}, BEAT_W'(done), 1);
        chk({tag, "_idle_valid"}, BEAT_W'(out_valid), 0);
        chk({tag, "_idle_ready"}, BEAT_W'(start_ready), 1);
    endtask

    initial begin
        logic [BEAT_W-1:0] v;
        int b;
        int cyc;
        logic rdy;

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; sel = '0; in_flat = '0;
        tick(); tick();
        chk("rst_start_ready", BEAT_W'(start_ready), 1);
        chk("rst_out_valid", BEAT_W'(out_valid), 0);
        chk("rst_out_last", BEAT_W'(out_last), 0);
        chk("rst_done", BEAT_W'(done), 0);
        chk("rst_err", BEAT_W'(err), 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        tick();

        // Basic stream, sel=2
        load_pattern();
        sel = 3'd2; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("basic_busy", BEAT_W'(start_ready), 0);
        v = out_data;
        chk("basic_b0_l0", BEAT_W'(v[15:0]), BEAT_W'(red(16'd2000)));
        run_full(2, "basic");
        tick();
        chk("basic_done_1cyc", BEAT_W'(done), 0);

        // Corner values for the reduction path
        v = exp_beat(2, 15);
        chk("basic_b15_l15", BEAT_W'(v[BEAT_W-1 -: COEFF_W]), BEAT_W'(16'd2255));

        // Backpressure + snapshot independence + busy start ignored
        sel = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        b = 0; cyc = 0;
        while (b < BEATS && cyc < 400) begin
            rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            start = (b == 5);
            sel = 3'd1;
            scramble();
            chk("bp_valid", BEAT_W'(out_valid), 1);
            chk("bp_data", out_data, exp_beat(4, b));
            chk("bp_last", BEAT_W'(out_last), BEAT_W'(b == BEATS-1));
            tick();
            if (rdy) b++;
            cyc++;
        end
        start = 1'b0;
        chk("bp_timeout", BEAT_W'(b), BEAT_W'(BEATS));
        chk("bp_done", BEAT_W'(done), 1);
        chk("bp_idle_valid", BEAT_W'(out_valid), 0);
        tick();
        chk("bp_no_restart", BEAT_W'(out_valid), 0);

        // Illegal select
        load_pattern();
        out_ready = 1'b1;
        sel = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_err", BEAT_W'(err), 1);
        chk("ill_valid", BEAT_W'(out_valid), 0);
        chk("ill_ready", BEAT_W'(start_ready), 1);
        chk("ill_done", BEAT_W'(done), 0);
        tick();
        chk("ill_err_1cyc", BEAT_W'(err), 0);
        chk("ill_valid2", BEAT_W'(out_valid), 0);

        // Reset mid-stream after beat 7
        sel = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("mid_data", out_data, exp_beat(1, i));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_valid", BEAT_W'(out_valid), 0);
        chk("mid_done", BEAT_W'(done), 0);
        chk("mid_ready", BEAT_W'(start_ready), 1);
        tick();
        chk("mid_done2", BEAT_W'(done), 0);
        sel = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        run_full(3, "after_rst");
        tick();

        // Reduction boundary values
        in_flat[0 +: 16]  = 16'd3328;
        in_flat[16 +: 16] = 16'd3329;
        in_flat[32 +: 16] = 16'd4000;
        sel = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef POLY_SEL_REDUCE_EN
        chk("red_3328", BEAT_W'(out_data[15:0]), 3328);
        chk("red_3329", BEAT_W'(out_data[31:16]), 0);
        chk("red_4000", BEAT_W'(out_data[47:32]), 671);
`else
        chk("red_3328", BEAT_W'(out_data[15:0]), 3328);
        chk("red_3329", BEAT_W'(out_data[31:16]), 3329);
        chk("red_4000", BEAT_W'(out_data[47:32]), 4000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
